uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
Parametrised UART receiver for the next-generation UART subsystem. Runs entirely in the system clock domain using an internal oversample tick, so the RX-side CDC FIFO and derived RX clock are no longer needed. Adds the following over the current receiver:
- configurable data bits (5..MAX_DATA_BITS) and oversample factor
- 3-sample majority voting and false-start rejection
- framing-error, break and overrun detection
- valid/ready output register
It sits between the rx_i pad and the RX buffering in the UART top.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
DIV_WIDTH, 16, width of the tick divider
MAX_DATA_BITS, 8, widest supported character; range 5..9

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
cfg_en_i  in  1  receiver enable
cfg_div_i  in  DIV_WIDTH  clk_i cycles per oversample tick; 0 is treated as 1
cfg_data_bits_i  in  4  data bits per character, 5..MAX_DATA_BITS
cfg_parity_en_i  in  1  parity bit present
cfg_parity_type_i  in  1  0 = even, 1 = odd
cfg_stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
rx_i  in  1  serial input, asynchronous
data_o  out  MAX_DATA_BITS  received character, LSB-first assembled, zero-extended
data_valid_o  out  1  character available
data_ready_i  in  1  consumer accepts
err_parity_o  out  1  parity error; qualified by data_valid_o
err_frame_o  out  1  stop-bit error; qualified by data_valid_o
break_o  out  1  one-cycle pulse on break detection
overrun_o  out  1  one-cycle pulse when a character is dropped

Behaviour:
- Reset: all outputs 0, FSM IDLE, tick and bit counters 0, synchroniser flops set to 1.
- Input synchronisation: rx_i passes through a 2-flop synchroniser. All logic uses the synchronised value.
- Tick generator: counts 0..max(cfg_div_i,1)-1 and emits a one-cycle tick at wrap. Count is held at 0 when cfg_en_i=0 or the FSM is IDLE. It restarts on start-edge detection.
- Config latching: cfg_* fields are latched at start-edge detection. Changes mid-frame have no effect until the next frame.
- Sampling: within each bit, samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three; the bit is resolved at the third sample.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
- IDLE -> START: on a synchronised 1->0 edge while cfg_en_i=1.
- START: if the majority is 1 (false start), go to IDLE with no output. If 0, go to DATA.
- DATA: shift in cfg_data_bits_i bits LSB first. Then go to PARITY if parity is enabled, otherwise STOP1.
- PARITY: compare the received bit against XOR(data) ^ cfg_parity_type_i; a mismatch sets the parity error.
- STOP1: a majority of 0 sets the frame error.
  - If every data bit, the parity bit (if present) and the stop bit are all 0: raise a break_o pulse, push no character, go to BREAK_WAIT.
  - Otherwise: go to STOP2 if cfg_stop_bits_i=1, else complete the frame.
- STOP2: same stop check as STOP1, then complete the frame.
- BREAK_WAIT: stay until the synchronised line is 1, then go to IDLE.
- Frame completion happens at the mid-bit of the final stop bit; the FSM returns to IDLE immediately, which allows resync.
- Output latency: data_valid_o rises the cycle after the final stop-bit majority resolves.
- Output register: one entry. data_o and the err_* flags are loaded together and held stable while data_valid_o=1 && data_ready_i=0.
  - Handshake completes on data_valid_o && data_ready_i; data_valid_o then drops next cycle unless a new character loads in that same cycle.
  - Completion while the register is full and ready=0: the new character is dropped, overrun_o pulses, the old contents are kept.
  - Completion in the same cycle as a handshake: the new character is loaded, no overrun.
- cfg_en_i=0: FSM forced to IDLE immediately, partial frame discarded, output register untouched.
- arst_i mid-frame: everything returns to reset values asynchronously; no partial character is emitted after release.

Decomposition:
- uart_pkg gains:
  - uart_rx_state_e enum
  - uart_rx_cfg_t struct (data_bits, parity_en, parity_type, stop_bits), used for the latched config
  - constants UART_MIN_DATA_BITS=5 and UART_MAX_DATA_BITS=9
- One sub-module: uart_os_tick (divider plus oversample counter producing tick and mid-sample strobes). It is reusable by a future oversampled transmitter.

Test Plan:
All scenarios use OVERSAMPLE=16 and cfg_div_i=4, giving 64 clk_i per bit.
1. 8N1 frame carrying 0xA5 -> data_o=0xA5, data_valid_o within 9.5*64+4 cycles of the start edge, err_parity_o=0, err_frame_o=0.
2. 7E2 frame carrying 0x3C with the parity bit driven 1 -> data_o=0x3C, err_parity_o=1, err_frame_o=0.
3. 8N1 frame carrying 0x55 with the stop bit driven 0 -> data_o=0x55, err_frame_o=1.
4. Line held low for 20 bit times -> one break_o pulse, no data_valid_o. A following 0x12 frame is received correctly.
5. Frames 0x11 then 0x22 with data_ready_i=0 -> data_o stays 0x11, overrun_o pulses once. Then data_ready_i=1 -> data_valid_o drops next cycle.
6. Line glitch low for 8 clk_i -> false start, no output. Assert arst_i mid-frame of 0x7E -> all outputs 0, no valid after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_e : receiver frame-state encoding
//   uart_rx_cfg_t   : per-frame configuration captured at the start edge
//   uart_clamp_bits : forces a data-bit count into the supported range
package uart_pkg;

    localparam int unsigned UART_MIN_DATA_BITS = 5;
    localparam int unsigned UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2,
        StBreakWait
    } uart_rx_state_e;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_en;
        logic       parity_type;
        logic       stop_bits;
    } uart_rx_cfg_t;

    // Out-of-range requests are clamped so the shift register index never leaves the data width.
    function automatic logic [3:0] uart_clamp_bits(input logic [3:0] bits,
                                                   input logic [3:0] max_bits);
        if (bits < 4'(UART_MIN_DATA_BITS)) begin
            return 4'(UART_MIN_DATA_BITS);
        end
        if (bits > max_bits) begin
            return max_bits;
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample timing: clock divider plus per-bit oversample counter.
//   clk, arst   : system clock, asynchronous active-high reset
//   run         : counting enable; when low both counters are held at 0 (acts as restart)
//   div         : clk cycles per oversample tick, 0 behaves as 1
//   sample      : strobe on each of the three mid-bit sample ticks
//   sample_last : strobe on the third mid-bit sample tick (bit resolves here)
module uart_os_tick #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 sample,
    output logic                 sample_last
);

    localparam int unsigned OsWidth = $clog2(OVERSAMPLE);
    localparam int unsigned Half    = OVERSAMPLE / 2;

    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_last;
    logic [OsWidth-1:0]   os_cnt_q;
    logic                 tick;

    assign div_last = (div == '0) ? '0 : div - DIV_WIDTH'(1);
    assign tick     = run && (div_cnt_q == div_last);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
        end else if (!run) begin
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
            os_cnt_q  <= (os_cnt_q == OsWidth'(OVERSAMPLE - 1)) ? '0 : os_cnt_q + OsWidth'(1);
        end else begin
            div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
        end
    end

    // os_cnt_q is the tick index before increment, so the samples land on the ticks that
    // bring the count to Half-1, Half and Half+1.
    assign sample      = tick && (os_cnt_q >= OsWidth'(Half - 2)) && (os_cnt_q <= OsWidth'(Half));
    assign sample_last = tick && (os_cnt_q == OsWidth'(Half));

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver running entirely on the system clock.
//   clk_i, arst_i        : system clock, asynchronous active-high reset
//   cfg_*_i              : enable, tick divider and frame format (captured per frame)
//   rx_i                 : asynchronous serial line
//   data_o, err_*_o      : received character and its error flags, valid/ready qualified
//   data_valid_o/ready_i : single-entry output register handshake
//   break_o, overrun_o   : one-cycle event pulses
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned DIV_WIDTH     = 16,
    parameter int unsigned MAX_DATA_BITS = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cfg_en_i,
    input  logic [DIV_WIDTH-1:0]     cfg_div_i,
    input  logic [3:0]               cfg_data_bits_i,
    input  logic                     cfg_parity_en_i,
    input  logic                     cfg_parity_type_i,
    input  logic                     cfg_stop_bits_i,
    input  logic                     rx_i,
    output logic [MAX_DATA_BITS-1:0] data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     err_parity_o,
    output logic                     err_frame_o,
    output logic                     break_o,
    output logic                     overrun_o
);

    logic                     sync1_q, sync2_q, rx_prev_q;
    uart_rx_state_e           state_q;
    uart_rx_cfg_t             cfg_q;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [MAX_DATA_BITS-1:0] shreg_q;
    logic [3:0]               bit_cnt_q;
    logic [1:0]               samp_q;
    logic                     par_err_q, frm_err_q, zero_q;

    logic run, sample, sample_last;
    logic start_det, maj, exp_par, stop_break, complete, frame_err_new, hs;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    uart_os_tick #(
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_WIDTH  (DIV_WIDTH)
    ) u_os_tick (
        .clk         (clk_i),
        .arst        (arst_i),
        .run         (run),
        .div         (div_q),
        .sample      (sample),
        .sample_last (sample_last)
    );

    assign run        = cfg_en_i && (state_q != StIdle);
    assign start_det  = cfg_en_i && (state_q == StIdle) && rx_prev_q && !sync2_q;
    // samp_q holds the first two samples of the bit; the third is the live line value.
    assign maj        = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync2_q) | (samp_q[0] & sync2_q);
    assign exp_par    = (^shreg_q) ^ cfg_q.parity_type;
    assign stop_break = !maj && zero_q;
    assign complete   = cfg_en_i && sample_last &&
                        (((state_q == StStop1) && !stop_break && !cfg_q.stop_bits) ||
                         (state_q == StStop2));
    assign frame_err_new = !maj || ((state_q == StStop2) && frm_err_q);
    assign hs            = data_valid_o && data_ready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= StIdle;
            cfg_q        <= '0;
            div_q        <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            zero_q       <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            err_parity_o <= 1'b0;
            err_frame_o  <= 1'b0;
            break_o      <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            break_o   <= 1'b0;
            overrun_o <= 1'b0;
            if (hs) begin
                data_valid_o <= 1'b0;
            end
            if (sample) begin
                samp_q <= {samp_q[0], sync2_q};
            end

            if (!cfg_en_i) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_det) begin
                            state_q   <= StStart;
                            cfg_q     <= '{data_bits:   uart_clamp_bits(cfg_data_bits_i,
                                                                        4'(MAX_DATA_BITS)),
                                           parity_en:   cfg_parity_en_i,
                                           parity_type: cfg_parity_type_i,
                                           stop_bits:   cfg_stop_bits_i};
                            div_q     <= cfg_div_i;
                            shreg_q   <= '0;
                            bit_cnt_q <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                            zero_q    <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (sample_last) begin
                            state_q <= maj ? StIdle : StData;
                        end
                    end
                    StData: begin
                        if (sample_last) begin
                            shreg_q <= shreg_q | (MAX_DATA_BITS'(maj) << bit_cnt_q);
                            zero_q  <= zero_q & ~maj;
                            if (bit_cnt_q == cfg_q.data_bits - 4'd1) begin
                                state_q <= cfg_q.parity_en ? StParity : StStop1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    StParity: begin
                        if (sample_last) begin
                            par_err_q <= (maj != exp_par);
                            zero_q    <= zero_q & ~maj;
                            state_q   <= StStop1;
                        end
                    end
                    StStop1: begin
                        if (sample_last) begin
                            if (stop_break) begin
                                break_o <= 1'b1;
                                state_q <= StBreakWait;
                            end else if (cfg_q.stop_bits) begin
                                frm_err_q <= !maj;
                                state_q   <= StStop2;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StStop2: begin
                        if (sample_last) begin
                            state_q <= StIdle;
                        end
                    end
                    StBreakWait: begin
                        if (sync2_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            // A handshake in the same cycle frees the register, so a completing frame loads.
            if (complete) begin
                if (!data_valid_o || data_ready_i) begin
                    data_o       <= shreg_q;
                    err_parity_o <= par_err_q;
                    err_frame_o  <= frame_err_new;
                    data_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule
